// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter with a small character queue.
// Frames are start bit, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
// A new frame starts directly after the last stop bit whenever the queue holds data,
// so characters go out back-to-back with no idle gap.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 tx_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow
);

  // Pointer index width, plus one wrap bit to tell full from empty.
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  // Baud counter wide enough to hold CLKS_PER_BIT-1.
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Queue storage and pointers
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic          full_reg, full_next;
  logic          empty_reg, empty_next;
  logic          overflow_reg, overflow_next;
  logic          push;
  logic          pop;
  logic [DATA_BITS-1:0] head;

  // ---------------------------------------------------------------------------
  // Transmit state
  // ---------------------------------------------------------------------------
  state_t               state_reg, state_next;
  logic [CW-1:0]        baud_cnt_reg, baud_cnt_next;
  logic [3:0]           bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_reg, parity_next;
  logic                 tx_reg, tx_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 bit_tick;
  logic                 head_parity;

  assign head = mem[rd_ptr_reg[AW-1:0]];

  // Parity bit for the character about to be loaded: even = XOR, odd = XNOR.
  assign head_parity = (PARITY == 1) ? ~(^head) : (^head);

  // Last cycle of the current bit time.
  assign bit_tick = (baud_cnt_reg == CNT_LAST);

  // Queue storage: written only on accepted pushes, contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= data;
    end
  end

  // Queue bookkeeping: a write into a full queue is still accepted when the
  // transmitter pops on the same edge, since a slot frees up at that moment.
  always_comb begin
    push          = tx_en && (!full_reg || pop);
    overflow_next = tx_en && full_reg && !pop;
    wr_ptr_next   = wr_ptr_reg + {{AW{1'b0}}, push};
    rd_ptr_next   = rd_ptr_reg + {{AW{1'b0}}, pop};
    empty_next    = (wr_ptr_next == rd_ptr_next);
    full_next     = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                    (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
  end

  // Queue pointer and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      full_reg     <= full_next;
      empty_reg    <= empty_next;
      overflow_reg <= overflow_next;
    end
  end

  // Frame sequencing: next state, line value for the next cycle, and the pop.
  always_comb begin
    state_next  = state_reg;
    bit_idx_next = bit_idx_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    tx_next     = tx_reg;
    done_next   = 1'b0;
    pop         = 1'b0;

    // The counter free-runs through a frame and restarts at each bit boundary,
    // so every bit is exactly CLKS_PER_BIT cycles and frames never drift.
    if (state_reg == S_IDLE || bit_tick) begin
      baud_cnt_next = '0;
    end else begin
      baud_cnt_next = baud_cnt_reg + 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        tx_next      = 1'b1;
        bit_idx_next = '0;
        if (!empty_reg) begin
          pop         = 1'b1;
          shift_next  = head;
          parity_next = head_parity;
          tx_next     = 1'b0;
          state_next  = S_START;
        end
      end

      S_START: begin
        if (bit_tick) begin
          bit_idx_next = '0;
          tx_next      = shift_reg[0];
          state_next   = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_tick) begin
          if (bit_idx_reg == DATA_LAST) begin
            bit_idx_next = '0;
            if (PARITY != 0) begin
              tx_next    = parity_reg;
              state_next = S_PARITY;
            end else begin
              tx_next    = 1'b1;
              state_next = S_STOP;
            end
          end else begin
            bit_idx_next = bit_idx_reg + 4'd1;
            shift_next   = shift_reg >> 1;
            tx_next      = shift_reg[1];
          end
        end
      end

      S_PARITY: begin
        if (bit_tick) begin
          bit_idx_next = '0;
          tx_next      = 1'b1;
          state_next   = S_STOP;
        end
      end

      S_STOP: begin
        if (bit_tick) begin
          if (bit_idx_reg == STOP_LAST) begin
            done_next    = 1'b1;
            bit_idx_next = '0;
            if (!empty_reg) begin
              // Chain straight into the next start bit.
              pop         = 1'b1;
              shift_next  = head;
              parity_next = head_parity;
              tx_next     = 1'b0;
              state_next  = S_START;
            end else begin
              tx_next    = 1'b1;
              state_next = S_IDLE;
            end
          end else begin
            bit_idx_next = bit_idx_reg + 4'd1;
          end
        end
      end

      default: begin
        tx_next    = 1'b1;
        state_next = S_IDLE;
      end
    endcase

    busy_next = (state_next != S_IDLE);
  end

  // Transmit registers; reset forces the line high at once, mid-frame included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      parity_reg   <= parity_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign tx       = tx_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign full     = full_reg;
  assign empty    = empty_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: four transmitter variants (8N1, 8E1, 8O1, 5N2) on one clock,
// checked every cycle against a frame-position model plus directed literals.
module tb_uart_tx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int NI    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_en [NI];
  logic [8:0] din [NI];
  logic       tx_o [NI];
  logic       busy_o [NI];
  logic       done_o [NI];
  logic       full_o [NI];
  logic       empty_o [NI];
  logic       ovf_o [NI];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_8n1 (
    .clk(clk), .reset(reset), .data(din[0][7:0]), .tx_en(tx_en[0]), .tx(tx_o[0]), .busy(busy_o[0]),
    .done(done_o[0]), .full(full_o[0]), .empty(empty_o[0]), .overflow(ovf_o[0]));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_8e1 (
    .clk(clk), .reset(reset), .data(din[1][7:0]), .tx_en(tx_en[1]), .tx(tx_o[1]), .busy(busy_o[1]),
    .done(done_o[1]), .full(full_o[1]), .empty(empty_o[1]), .overflow(ovf_o[1]));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_8o1 (
    .clk(clk), .reset(reset), .data(din[2][7:0]), .tx_en(tx_en[2]), .tx(tx_o[2]), .busy(busy_o[2]),
    .done(done_o[2]), .full(full_o[2]), .empty(empty_o[2]), .overflow(ovf_o[2]));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_5n2 (
    .clk(clk), .reset(reset), .data(din[3][4:0]), .tx_en(tx_en[3]), .tx(tx_o[3]), .busy(busy_o[3]),
    .done(done_o[3]), .full(full_o[3]), .empty(empty_o[3]), .overflow(ovf_o[3]));

  // ---------------- model: queue + position within the current frame ----------------
  function automatic int db(input int k); return (k == 3) ? 5 : 8; endfunction
  function automatic int pm(input int k); return (k == 1) ? 2 : ((k == 2) ? 1 : 0); endfunction
  function automatic int sb(input int k); return (k == 3) ? 2 : 1; endfunction
  function automatic int flen(input int k);
    return (1 + db(k) + ((pm(k) != 0) ? 1 : 0) + sb(k)) * CPB;
  endfunction

  // Line level during bit number idx of a frame carrying character ch.
  function automatic logic line_bit(input int k, input int ch, input int idx);
    int ones;
    ones = $countones(ch);
    if (idx == 0) return 1'b0;
    if (idx <= db(k)) return 1'((ch >> (idx - 1)) & 1);
    if (pm(k) != 0 && idx == db(k) + 1) return (pm(k) == 2) ? 1'(ones % 2) : 1'(1 - ones % 2);
    return 1'b1;
  endfunction

  int         mq [NI][DEPTH];
  int         mcnt [NI];
  bit         mact [NI];
  int         mpos [NI];
  int         mch [NI];
  logic [5:0] ex [NI];   // {tx, busy, done, full, empty, overflow}

  task automatic model_clear();
    for (int k = 0; k < NI; k++) begin
      mcnt[k] = 0; mact[k] = 1'b0; mpos[k] = 0; mch[k] = 0;
      ex[k] = 6'b100010;
    end
  endtask

  task automatic model_step(input int k);
    bit fend, popn, fullb, acc, ovf;
    fend  = mact[k] && (mpos[k] == flen(k) - 1);
    popn  = (mcnt[k] > 0) && (!mact[k] || fend);
    fullb = (mcnt[k] == DEPTH);
    acc   = tx_en[k] && (!fullb || popn);
    ovf   = tx_en[k] && fullb && !popn;
    if (popn) begin
      mch[k] = mq[k][0];
      for (int i = 0; i < DEPTH - 1; i++) mq[k][i] = mq[k][i + 1];
      mcnt[k]--;
      mact[k] = 1'b1;
      mpos[k] = 0;
    end else if (fend) begin
      mact[k] = 1'b0;
    end else if (mact[k]) begin
      mpos[k]++;
    end
    if (acc) begin
      mq[k][mcnt[k]] = int'(din[k]) & ((1 << db(k)) - 1);
      mcnt[k]++;
    end
    ex[k] = {mact[k] ? line_bit(k, mch[k], mpos[k] / CPB) : 1'b1, mact[k], fend,
             mcnt[k] == DEPTH, mcnt[k] == 0, ovf};
  endtask

  // Model advances on every edge, and clears the moment reset falls.
  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_clear();
      else for (int k = 0; k < NI; k++) model_step(k);
    end
  end

  // Every-cycle comparison of all outputs of all instances against the model.
  initial begin
    logic [5:0] got;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        got = {tx_o[k], busy_o[k], done_o[k], full_o[k], empty_o[k], ovf_o[k]};
        n_vec++;
        if (got !== ex[k]) begin
          n_miss++;
          $display("FAIL cycle inst%0d t=%0t {tx,busy,done,full,empty,ovf} got %b want %b", k, $time, got, ex[k]);
        end
      end
    end
  end

  // ---------------- directed stimulus and literal expectations ----------------
  task automatic lit(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, got, got, want, want);
    end
  endtask

  // One character to every instance, then sample each bit mid-way and time done/busy.
  task automatic run_char(input int v8, input int v5, input logic [10:0] e0, input logic [10:0] e1,
                          input logic [10:0] e2, input logic [10:0] e3);
    logic [10:0] s [NI];
    int first_done [NI];
    int nbusy [NI];
    int ndone [NI];
    for (int k = 0; k < NI; k++) begin
      first_done[k] = -1; nbusy[k] = 0; ndone[k] = 0; s[k] = '0;
      tx_en[k] = 1'b1;
      din[k] = (k == 3) ? 9'(v5) : 9'(v8);
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) tx_en[k] = 1'b0;
    fork
      begin
        repeat (9) @(negedge clk);
        for (int b = 0; b < 11; b++) begin
          for (int k = 0; k < NI; k++) s[k][b] = tx_o[k];
          if (b < 10) repeat (CPB) @(negedge clk);
        end
      end
      begin
        for (int n = 1; n <= 400; n++) begin
          @(negedge clk);
          for (int k = 0; k < NI; k++) begin
            if (done_o[k]) begin
              ndone[k]++;
              if (first_done[k] < 0) first_done[k] = n;
            end
            if (busy_o[k]) nbusy[k]++;
          end
        end
      end
    join
    lit("bits_8n1", int'(s[0]), int'(e0));
    lit("bits_8e1", int'(s[1]), int'(e1));
    lit("bits_8o1", int'(s[2]), int'(e2));
    lit("bits_5n2", int'(s[3]), int'(e3));
    lit("done_at_8n1", first_done[0], 161);
    lit("busy_len_8n1", nbusy[0], 160);
    lit("done_cnt_8n1", ndone[0], 1);
    lit("done_at_8e1", first_done[1], 177);
    lit("busy_len_8e1", nbusy[1], 176);
    lit("done_at_5n2", first_done[3], 129);
    lit("busy_len_5n2", nbusy[3], 128);
  endtask

  initial begin
    int dt [8];
    int nd;
    int low_at;
    int tx_low;
    for (int k = 0; k < NI; k++) begin
      tx_en[k] = 1'b0;
      din[k] = '0;
    end
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    lit("rst_tx", int'(tx_o[0]), 1);
    lit("rst_empty", int'(empty_o[0]), 1);
    lit("rst_busy", int'(busy_o[0]), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single characters, all formats; A9 then 01 for the parity cases.
    run_char(8'hA9, 5'h1B, 11'b11101010010, 11'b10101010010, 11'b11101010010, 11'b11111110110);
    run_char(8'h01, 5'h04, 11'b11000000010, 11'b11000000010, 11'b10000000010, 11'b11111001000);

    // Back-to-back: four writes on consecutive edges.
    tx_en[0] = 1'b1; din[0] = 9'h055;
    @(negedge clk); din[0] = 9'h0AA;
    @(negedge clk); din[0] = 9'h00F;
    @(negedge clk); din[0] = 9'h0F0;
    @(negedge clk); tx_en[0] = 1'b0;
    nd = 0; low_at = -1;
    for (int n = 4; n <= 800; n++) begin
      @(negedge clk);
      if (done_o[0]) begin
        if (nd < 8) dt[nd] = n;
        nd++;
      end
      if (!busy_o[0] && low_at < 0) low_at = n;
    end
    lit("b2b_done_cnt", nd, 4);
    lit("b2b_done1", dt[0], 161);
    lit("b2b_done4", dt[3], 641);
    lit("b2b_busy_fall", low_at, 641);

    // Overflow: one frame in flight, fill the queue, then one dropped write.
    tx_en[0] = 1'b1; din[0] = 9'h011;
    @(negedge clk); tx_en[0] = 1'b0;                       // n=0
    @(negedge clk); tx_en[0] = 1'b1; din[0] = 9'h022;      // n=1
    @(negedge clk); din[0] = 9'h044;
    @(negedge clk); din[0] = 9'h066;
    @(negedge clk); din[0] = 9'h088;
    @(negedge clk);                                         // n=5
    lit("ovf_full_set", int'(full_o[0]), 1);
    din[0] = 9'h033;
    @(negedge clk); tx_en[0] = 1'b0;                        // n=6
    lit("ovf_pulse", int'(ovf_o[0]), 1);
    @(negedge clk);                                         // n=7
    lit("ovf_clear", int'(ovf_o[0]), 0);
    repeat (153) @(negedge clk);                            // n=160
    tx_en[0] = 1'b1; din[0] = 9'h077;
    @(negedge clk); tx_en[0] = 1'b0;                        // n=161: pop edge
    lit("pop_wr_full", int'(full_o[0]), 1);
    lit("pop_wr_done", int'(done_o[0]), 1);
    nd = 0; low_at = -1;
    for (int n = 162; n <= 1000; n++) begin
      @(negedge clk);
      if (done_o[0]) nd++;
      if (!busy_o[0] && low_at < 0) low_at = n;
    end
    lit("ovf_done_cnt", nd, 5);
    lit("ovf_busy_fall", low_at, 961);

    // Reset during data bit 3 of the first of two queued frames.
    tx_en[0] = 1'b1; din[0] = 9'h0C3;
    @(negedge clk); din[0] = 9'h03C;
    @(negedge clk); tx_en[0] = 1'b0;                        // n=1
    repeat (71) @(negedge clk);                             // n=72
    lit("pre_rst_tx", int'(tx_o[0]), 0);
    #2 reset = 1'b0;
    #1;
    lit("mid_rst_tx", int'(tx_o[0]), 1);
    lit("mid_rst_busy", int'(busy_o[0]), 0);
    lit("mid_rst_empty", int'(empty_o[0]), 1);
    lit("mid_rst_done", int'(done_o[0]), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    nd = 0; tx_low = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done_o[0]) nd++;
      if (!tx_o[0]) tx_low++;
    end
    lit("post_rst_done", nd, 0);
    lit("post_rst_tx_low", tx_low, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
